maxpool_channel_sequencer: RTL and testbench
============================================

Name: maxpool_channel_sequencer

Overview:
- Sequences multi-channel feature maps through a 3x3 stride-2 max-pooling core, one channel plane at a time.
- Gates the raster pixel stream into the core and counts input and output pixels per channel.
- Flushes the core's line buffers between channels with a local reset pulse.
- Reports busy/done/error to the layer scheduler. Sits between the feature-map reader and the pooling core.

Parameters:
- DATA_WIDHT, 32, pixel word width
- IMG_WIDHT, 299, input plane width (odd, >=3)
- IMG_HEIGHT, 299, input plane height (odd, >=3)
- CH_WIDTH, 10, width of channel-count input
- FLUSH_CYCLES, 4, cycles core_rst is held between channels (>=1)
- DRAIN_TIMEOUT, 1024, max cycles waiting for the core's last output after the last input

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle launch pulse; sampled only in IDLE
- num_channels  in  CH_WIDTH  channel count, latched on accepted start
- src_data  in  DATA_WIDHT  input pixel
- src_valid  in  1  input pixel valid
- src_ready  out  1  sequencer accepts input pixel
- core_data_in  out  DATA_WIDHT  to core Data_In
- core_valid_in  out  1  to core Valid_In
- core_rst  out  1  to core rst
- core_data_out  in  DATA_WIDHT  from core Data_Out
- core_valid_out  in  1  from core Valid_Out
- out_data  out  DATA_WIDHT  pooled pixel
- out_valid  out  1  pooled pixel valid
- out_last  out  1  marks last pooled pixel of a channel
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of job
- error  out  1  sticky drain-timeout flag; cleared on next accepted start
- cur_channel  out  CH_WIDTH  index of channel in progress

Behaviour:
- Constants:
  - IN_PIX = IMG_WIDHT*IMG_HEIGHT.
  - OUT_W = (IMG_WIDHT-3)/2+1; OUT_H = (IMG_HEIGHT-3)/2+1; OUT_PIX = OUT_W*OUT_H (299x299 gives 149x149 = 22201).
- Reset:
  - State goes to IDLE.
  - All outputs 0, except core_rst = 1 while rst is asserted.
  - Counters and error cleared.
  - rst asserted mid-job aborts the job immediately; no done pulse.
- States: IDLE, FLUSH, FEED, DRAIN, NEXT, FIN.
- IDLE:
  - start with num_channels != 0: latch count, cur_channel = 0, clear error, busy = 1, go to FLUSH.
  - start with num_channels == 0: go to FIN, no pixels transferred.
  - start in any other state is ignored.
- FLUSH: core_rst = 1 for FLUSH_CYCLES cycles, clear in/out counters, then go to FEED.
- FEED:
  - src_ready = 1.
  - core_valid_in = src_valid & src_ready; core_data_in = src_data (combinational, zero latency).
  - in_cnt increments per accepted pixel.
  - When in_cnt reaches IN_PIX-1 and a pixel is accepted, go to DRAIN (src_ready = 0 from the next cycle).
- DRAIN:
  - src_ready = 0.
  - Wait for out_cnt == OUT_PIX.
  - Timer counts from DRAIN entry; reaching DRAIN_TIMEOUT sets error and forces transition.
- Output path (FEED and DRAIN only):
  - out_data/out_valid are core outputs registered one cycle.
  - out_cnt increments per core_valid_out.
  - out_last = 1 with the OUT_PIX-th output.
  - core_valid_out in other states, or beyond OUT_PIX, is dropped and not counted.
- NEXT (one cycle):
  - If cur_channel == num_channels-1, go to FIN.
  - Else cur_channel++ and go to FLUSH.
- FIN: done = 1 for one cycle, busy = 0 from the following cycle, go to IDLE.
- Input and output may overlap in the same cycle; counters are independent.
- Counter widths: clog2(IN_PIX+1) and clog2(OUT_PIX+1); no wrap within a channel.

Optional Feature:
- Macro: MAXPOOL_SEQ_PERF_EN.
- Defined:
  - Adds output port stall_cycles (32 bits): counts FEED cycles with src_valid = 0, cleared on accepted start, saturates at all-ones.
  - Adds output port job_cycles (32 bits): counts cycles busy is high, same clear and saturation rules.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Params 7x7 (IN_PIX 49, OUT_PIX 9), num_channels = 1, continuous src_valid, model core -> 49 inputs accepted; 9 out_valid with out_last on the 9th; done pulse; busy low the next cycle.
- num_channels = 3, src_valid toggled 50% -> core_rst high 4 cycles before each channel; cur_channel steps 0,1,2; 27 outputs total; 3 out_last pulses; exactly one done.
- num_channels = 0 -> done 2 cycles after start; src_ready never high; no core_rst pulse apart from reset.
- Core model withholds its last output, DRAIN_TIMEOUT = 16 -> error = 1 after 16 DRAIN cycles; sequencer proceeds to next channel; error cleared by next start.
- rst asserted mid-FEED of channel 1 of 2 -> all outputs 0 asynchronously; no done; a new start runs a clean 9-output channel.
- start pulsed during FEED, plus core_valid_out injected in IDLE -> both ignored; counts unchanged.

Source files
------------

// File: rtl/maxpool_channel_sequencer.sv
// Channel sequencer for a 3x3 stride-2 max-pooling core: gates pixels, flushes between planes, counts I/O.
// Optional performance counters (stall_cycles, job_cycles) are enabled with `define MAXPOOL_SEQ_PERF_EN.
module maxpool_channel_sequencer #(
    parameter int DATA_WIDHT    = 32,
    parameter int IMG_WIDHT     = 299,
    parameter int IMG_HEIGHT    = 299,
    parameter int CH_WIDTH      = 10,
    parameter int FLUSH_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CH_WIDTH-1:0]   num_channels,
    input  logic [DATA_WIDHT-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDHT-1:0] core_data_in,
    output logic                  core_valid_in,
    output logic                  core_rst,
    input  logic [DATA_WIDHT-1:0] core_data_out,
    input  logic                  core_valid_out,
    output logic [DATA_WIDHT-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CH_WIDTH-1:0]   cur_channel
`ifdef MAXPOOL_SEQ_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           job_cycles
`endif
);

    localparam int IN_PIX  = IMG_WIDHT * IMG_HEIGHT;
    localparam int OUT_W   = (IMG_WIDHT - 3) / 2 + 1;
    localparam int OUT_H   = (IMG_HEIGHT - 3) / 2 + 1;
    localparam int OUT_PIX = OUT_W * OUT_H;

    localparam int IN_CW  = $clog2(IN_PIX + 1);
    localparam int OUT_CW = $clog2(OUT_PIX + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);
    localparam int TM_W   = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_PIX - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_PIX - 1);
    localparam logic [OUT_CW-1:0] OUT_ALL  = OUT_CW'(OUT_PIX);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [TM_W-1:0]   TM_LAST  = TM_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FEED,
        DRAIN,
        NEXT,
        FIN
    } state_t;

    state_t              state;
    logic [CH_WIDTH-1:0] num_ch;
    logic [IN_CW-1:0]    in_cnt;
    logic [OUT_CW-1:0]   out_cnt;
    logic [FL_W-1:0]     flush_cnt;
    logic [TM_W-1:0]     timer;
    logic                flush_rst;
    logic                out_window;

    assign core_valid_in = src_valid & src_ready;
    assign core_data_in  = src_ready ? src_data : '0;
    // The core is held in reset both by the flush pulse and, asynchronously, by the system reset.
    assign core_rst      = flush_rst | rst;
    assign out_window    = (state == FEED) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_ch      <= '0;
            cur_channel <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            flush_cnt   <= '0;
            timer       <= '0;
            flush_rst   <= 1'b0;
            src_ready   <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;

            if (out_window && core_valid_out && (out_cnt != OUT_ALL)) begin
                out_valid <= 1'b1;
                out_data  <= core_data_out;
                out_last  <= (out_cnt == OUT_LAST);
                out_cnt   <= out_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    flush_rst <= 1'b0;
                    if (done) begin
                        busy <= 1'b0;
                    end
                    if (start) begin
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        num_ch      <= num_channels;
                        cur_channel <= '0;
                        if (num_channels != '0) begin
                            flush_rst <= 1'b1;
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end else begin
                            state <= FIN;
                        end
                    end
                end

                FLUSH: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    timer   <= '0;
                    if (flush_cnt == FL_LAST) begin
                        flush_rst <= 1'b0;
                        src_ready <= 1'b1;
                        state     <= FEED;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                FEED: begin
                    if (core_valid_in) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == IN_LAST) begin
                            src_ready <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (out_cnt == OUT_ALL) begin
                        state <= NEXT;
                    end else if (timer == TM_LAST) begin
                        error <= 1'b1;
                        state <= NEXT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                NEXT: begin
                    if (cur_channel == num_ch - 1'b1) begin
                        state <= FIN;
                    end else begin
                        cur_channel <= cur_channel + 1'b1;
                        flush_rst   <= 1'b1;
                        flush_cnt   <= '0;
                        state       <= FLUSH;
                    end
                end

                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAXPOOL_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else begin
            if ((state == FEED) && !src_valid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (busy && (job_cycles != '1)) begin
                job_cycles <= job_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_channel_sequencer.sv
// Self-checking bench for maxpool_channel_sequencer with a behavioural pooling core and reference model.
module tb_maxpool_channel_sequencer;

    localparam int DW = 16, W = 7, H = 7, CW = 4, FL = 4, TO = 16;
    localparam int IN_PIX = W * H;
    localparam int OW = (W - 3) / 2 + 1, OH = (H - 3) / 2 + 1;
    localparam int OUT_PIX = OW * OH;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, src_valid = 1'b0;
    logic [CW-1:0] num_channels = '0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready, core_valid_in, core_rst, out_valid, out_last, busy, done, error;
    logic [DW-1:0] core_data_in, out_data;
    logic [CW-1:0] cur_channel;
    logic [DW-1:0] core_data_out = '0;
    logic          core_valid_out = 1'b0;
`ifdef MAXPOOL_SEQ_PERF_EN
    logic [31:0]   stall_cycles, job_cycles;
`endif

    maxpool_channel_sequencer #(
        .DATA_WIDHT(DW), .IMG_WIDHT(W), .IMG_HEIGHT(H),
        .CH_WIDTH(CW), .FLUSH_CYCLES(FL), .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_channels(num_channels),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .core_data_in(core_data_in), .core_valid_in(core_valid_in), .core_rst(core_rst),
        .core_data_out(core_data_out), .core_valid_out(core_valid_out),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done), .error(error), .cur_channel(cur_channel)
`ifdef MAXPOOL_SEQ_PERF_EN
        , .stall_cycles(stall_cycles), .job_cycles(job_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [DW-1:0] img [0:3][0:IN_PIX-1];
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];

    // Pooling core stand-in: stores the plane, emits each window max one cycle after it completes.
    logic [DW-1:0] cimg [0:IN_PIX-1];
    logic [DW-1:0] cq[$];
    int ccnt = 0, cprod = 0;
    bit withhold = 0, inject = 0;

    always begin : core_model
        bit a, r;
        logic [DW-1:0] d, m;
        int row, col;
        @(negedge clk); #4;
        a = core_valid_in; r = core_rst; d = core_data_in;
        @(posedge clk); #1;
        if (r) begin
            ccnt = 0; cprod = 0; cq.delete();
        end else if (a && ccnt < IN_PIX) begin
            cimg[ccnt] = d; row = ccnt / W; col = ccnt % W; ccnt++;
            if (row >= 2 && col >= 2 && row % 2 == 0 && col % 2 == 0) begin
                m = '0;
                for (int di = 0; di < 3; di++)
                    for (int dj = 0; dj < 3; dj++)
                        if (cimg[(row - 2 + di) * W + col - 2 + dj] > m) m = cimg[(row - 2 + di) * W + col - 2 + dj];
                cprod++;
                if (!(withhold && cprod == OUT_PIX)) cq.push_back(m);
            end
        end
        if (inject) begin
            core_valid_out = 1'b1; core_data_out = DW'($urandom);
        end else if (cq.size() > 0) begin
            core_valid_out = 1'b1; core_data_out = cq.pop_front();
        end else begin
            core_valid_out = 1'b0; core_data_out = '0;
        end
    end

    logic [DW-1:0] out_d[$];
    bit            out_l[$];
    int ch_q[$], flush_q[$];
    int acc_cnt = 0, done_cnt = 0, ready_cnt = 0, crst_rises = 0, run_len = 0;
    bit prev_crst = 1'b1;

    always begin : monitor
        @(negedge clk); #4;
        if (core_valid_in) acc_cnt++;
        if (out_valid) begin out_d.push_back(out_data); out_l.push_back(out_last); end
        if (done) done_cnt++;
        if (src_ready) ready_cnt++;
        if (core_rst) begin
            if (!prev_crst) begin crst_rises++; ch_q.push_back(int'(cur_channel)); end
            run_len++;
        end else if (prev_crst) begin
            flush_q.push_back(run_len); run_len = 0;
        end
        prev_crst = core_rst;
    end

    task automatic clear_mon();
        out_d.delete(); out_l.delete(); ch_q.delete(); flush_q.delete();
        acc_cnt = 0; done_cnt = 0; ready_cnt = 0; crst_rises = 0; run_len = 0;
    endtask

    task automatic new_images();
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < IN_PIX; p++) img[c][p] = DW'($urandom);
    endtask

    // Reference: every 3x3 window at stride 2 of each plane, in raster order, last flag on the final one.
    function automatic void build_expected(input int nch, input int drop_ch);
        logic [DW-1:0] m;
        exp_d.delete(); exp_l.delete();
        for (int c = 0; c < nch; c++)
            for (int k = 0; k < OUT_PIX; k++) begin
                if (c == drop_ch && k == OUT_PIX - 1) continue;
                m = '0;
                for (int di = 0; di < 3; di++)
                    for (int dj = 0; dj < 3; dj++)
                        if (img[c][(2 * (k / OW) + di) * W + 2 * (k % OW) + dj] > m)
                            m = img[c][(2 * (k / OW) + di) * W + 2 * (k % OW) + dj];
                exp_d.push_back(m); exp_l.push_back(k == OUT_PIX - 1);
            end
    endfunction

    task automatic pulse_start(input int n);
        @(negedge clk); num_channels = CW'(n); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed(input int ch, input int from, input int to, input int pct, output bit ok);
        int p = from, guard = 0;
        while (p < to && guard < 2000) begin
            @(negedge clk);
            src_valid = ($urandom_range(99) < pct);
            src_data  = img[ch][p];
            #2;
            if (src_valid && src_ready) p++;
            guard++;
        end
        @(negedge clk); src_valid = 1'b0;
        ok = (p == to);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({src_ready, busy, done, error, out_valid, out_last, core_valid_in} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000",
                {src_ready, busy, done, error, out_valid, out_last, core_valid_in});
        end
        checks++;
        if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
        checks++;
        if (out_data !== '0 || cur_channel !== '0 || core_data_in !== '0) begin
            errors++; $display("FAIL reset_data: out_data %h cur_channel %0d core_data_in %h expected 0", out_data, cur_channel, core_data_in);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: core_rst %b busy %b expected 0 0", core_rst, busy);
        end
        clear_mon();
    endtask

    task automatic test_single_channel();
        bit ok; int n;
        clear_mon(); new_images(); build_expected(1, -1);
        pulse_start(1);
        feed(0, 0, IN_PIX, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_feed: feed budget expired, got timeout expected 49 accepts"); end
        wait_done(n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b after %0d cycles expected 1", done, n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_done: got %b expected 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL single_busy_after_done: busy %b done %b expected 0 0", busy, done);
        end
        repeat (2) @(negedge clk);
        checks++; if (acc_cnt != IN_PIX) begin errors++; $display("FAIL single_accepts: got %0d expected %0d", acc_cnt, IN_PIX); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (flush_q.size() != 1 || flush_q[0] != FL) begin
            errors++; $display("FAIL single_flush: got %0d pulses expected 1 of %0d cycles", flush_q.size(), FL);
        end
        checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL single_out_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
            checks++;
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL single_out[%0d]: got %h/%b expected %h/%b", k, out_d[k], out_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_multi_channel();
        bit ok; int n;
        clear_mon(); new_images(); build_expected(3, -1);
        pulse_start(3);
        for (int c = 0; c < 3; c++) begin
            feed(c, 0, IN_PIX, 50, ok);
            checks++; if (!ok) begin errors++; $display("FAIL multi_feed ch%0d: got timeout expected 49 accepts", c); end
        end
        wait_done(n);
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt); end
        checks++; if (ch_q.size() != 3) begin errors++; $display("FAIL multi_flushes: got %0d expected 3", ch_q.size()); end
        for (int c = 0; c < ch_q.size() && c < 3; c++) begin
            checks++;
            if (ch_q[c] != c || flush_q[c] != FL) begin
                errors++; $display("FAIL multi_flush[%0d]: channel %0d len %0d expected channel %0d len %0d", c, ch_q[c], flush_q[c], c, FL);
            end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL multi_error: got %b expected 0", error); end
        checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL multi_out_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
            checks++;
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL multi_out[%0d]: got %h/%b expected %h/%b", k, out_d[k], out_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_zero_channels();
        clear_mon();
        pulse_start(0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_cycle1: done %b busy %b expected 0 1", done, busy);
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_cycle2: got %b expected 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_cycle3: done %b busy %b expected 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ready_cnt != 0 || crst_rises != 0 || done_cnt != 1 || out_d.size() != 0) begin
            errors++; $display("FAIL zero_activity: ready %0d core_rst %0d done %0d outs %0d expected 0 0 1 0",
                ready_cnt, crst_rises, done_cnt, out_d.size());
        end
    endtask

    task automatic test_drain_timeout();
        bit ok; int n;
        clear_mon(); new_images(); build_expected(2, 0);
        withhold = 1'b1;
        pulse_start(2);
        feed(0, 0, IN_PIX, 100, ok);
        withhold = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_error_early: got %b expected 0", error); end
        n = 0;
        while (error !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
        feed(1, 0, IN_PIX, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_next_channel: got timeout expected 49 accepts"); end
        wait_done(n);
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL timeout_sticky: error %b done %0d expected 1 1", error, done_cnt);
        end
        checks++;
        if (ch_q.size() != 2 || ch_q[ch_q.size() - 1] != 1) begin
            errors++; $display("FAIL timeout_channels: got %0d flushes expected 2 ending at channel 1", ch_q.size());
        end
        checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL timeout_out_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
            checks++;
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL timeout_out[%0d]: got %h/%b expected %h/%b", k, out_d[k], out_l[k], exp_d[k], exp_l[k]);
            end
        end
        pulse_start(1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_error_clear: got %b expected 0", error); end
        feed(0, 0, IN_PIX, 100, ok);
        wait_done(n);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit ok; int n;
        clear_mon(); new_images();
        pulse_start(2);
        feed(0, 0, IN_PIX, 100, ok);
        feed(1, 0, 20, 100, ok);
        checks++;
        if (cur_channel !== CW'(1) || src_ready !== 1'b1) begin
            errors++; $display("FAIL abort_pre: cur_channel %0d src_ready %b expected 1 1", cur_channel, src_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({src_ready, busy, done, error, out_valid, out_last, core_valid_in} !== 7'b0 || cur_channel !== '0 || out_data !== '0) begin
            errors++; $display("FAIL abort_outputs: flags %b cur_channel %0d out_data %h expected all 0",
                {src_ready, busy, done, error, out_valid, out_last, core_valid_in}, cur_channel, out_data);
        end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL abort_core_rst: got %b expected 1", core_rst); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done %0d busy %b expected 0 0", done_cnt, busy);
        end
        clear_mon(); new_images(); build_expected(1, -1);
        pulse_start(1);
        feed(0, 0, IN_PIX, 100, ok);
        wait_done(n);
        repeat (3) @(negedge clk);
        checks++;
        if (acc_cnt != IN_PIX || done_cnt != 1) begin
            errors++; $display("FAIL abort_rerun: accepts %0d done %0d expected %0d 1", acc_cnt, done_cnt, IN_PIX);
        end
        checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL abort_out_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
            checks++;
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL abort_out[%0d]: got %h/%b expected %h/%b", k, out_d[k], out_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok; int n;
        clear_mon();
        @(negedge clk); inject = 1'b1;
        repeat (4) @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_d.size() != 0) begin errors++; $display("FAIL ignore_idle_outputs: got %0d expected 0", out_d.size()); end
        clear_mon(); new_images(); build_expected(1, -1);
        pulse_start(1);
        feed(0, 0, 15, 100, ok);
        num_channels = CW'(3); start = 1'b1;
        @(negedge clk); start = 1'b0;
        feed(0, 15, IN_PIX, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ignore_feed: got timeout expected 49 accepts"); end
        wait_done(n);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || crst_rises != 1 || acc_cnt != IN_PIX) begin
            errors++; $display("FAIL ignore_start: done %0d flushes %0d accepts %0d expected 1 1 %0d",
                done_cnt, crst_rises, acc_cnt, IN_PIX);
        end
        checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL ignore_out_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
        for (int k = 0; k < exp_d.size() && k < out_d.size(); k++) begin
            checks++;
            if (out_d[k] !== exp_d[k] || out_l[k] !== exp_l[k]) begin
                errors++; $display("FAIL ignore_out[%0d]: got %h/%b expected %h/%b", k, out_d[k], out_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    initial begin
        new_images();
        test_reset();
        test_single_channel();
        test_multi_channel();
        test_zero_channels();
        test_drain_timeout();
        test_reset_abort();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1);
    end

endmodule
